bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Round-robin arbiter for the shared system bus with four masters (m0..m3).
- Generates the active-low grants that drive the bus master multiplexer and the per-master grant inputs.
- Exactly one master owns the bus at all times. A programmable tenure limit stops any single master from starving the others.

Parameters:
- MAX_HOLD, 16: maximum consecutive cycles an owner keeps the bus while another master is requesting. 0 disables preemption.
- HOLD_W, 8: width of the tenure counter. MAX_HOLD must be at most 2^HOLD_W - 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_  input  1  synchronous, active-low reset (sampled on rising clk).
- m0Req_  input  1  master 0 bus request, active-low.
- m1Req_  input  1  master 1 bus request, active-low.
- m2Req_  input  1  master 2 bus request, active-low.
- m3Req_  input  1  master 3 bus request, active-low.
- m0Grnt_  output  1  master 0 grant, active-low, registered.
- m1Grnt_  output  1  master 1 grant, active-low, registered.
- m2Grnt_  output  1  master 2 grant, active-low, registered.
- m3Grnt_  output  1  master 3 grant, active-low, registered.
- owner  output  2  index of the current owner; always consistent with the grants.
- preempt  output  1  one-cycle high pulse in the cycle a forced handover takes effect.

Behaviour:
- Reset (reset_ low at a clk edge):
  - owner = 0; m0Grnt_ = 0; m1Grnt_/m2Grnt_/m3Grnt_ = 1.
  - preempt = 0; tenure counter = 0.
  - Reset mid-tenure or mid-handover returns ownership to m0 at the next edge, regardless of requests.
- Grant invariant: exactly one mNGrnt_ is low every cycle. The low grant is the one whose index equals owner. No cycle has zero grants or more than one grant.
- State:
  - owner register (2 bits).
  - tenure counter hold (HOLD_W bits).
  - Grant outputs are a registered one-hot-low decode of the next owner, so grants and owner change in the same cycle.
- Next-owner search order: (owner+1) mod 4, (owner+2) mod 4, (owner+3) mod 4. The first master with Req_ low wins. The current owner is never in the search list.
- Normal release: owner's Req_ high at an edge, and at least one other Req_ low → owner takes the search winner at that edge. Latency: one cycle from the owner releasing to the new grant.
- Idle park: owner's Req_ high and no other request → owner unchanged; the grant stays parked on the current owner.
- Continued hold: owner's Req_ low → owner unchanged unless preempted.
- Tenure counter:
  - Cleared on every ownership change.
  - Cleared while the owner's Req_ is high.
  - Cleared while no other master requests.
  - Otherwise increments by 1 per cycle and saturates at MAX_HOLD.
- Preemption (MAX_HOLD != 0):
  - Fires when the owner's Req_ is low, another Req_ is low, and hold == MAX_HOLD-1 at an edge.
  - At that edge owner takes the search winner, hold clears, and preempt is high for the following cycle only.
  - The preempted master must keep its Req_ low to re-enter rotation. It is served again only after the others in round-robin order.
- Simultaneous events:
  - Owner release and preemption condition in the same cycle → treated as a normal release; preempt stays 0.
  - A request arriving on the same edge as an owner release is eligible in that search.
- preempt is 0 in every cycle not immediately following a forced handover.
- MAX_HOLD = 0: counter held at 0, preempt constant 0, owner changes only on release.
- No combinational path from any Req_ input to any output.

Test Plan:
- Reset with all Req_ = 1 → m0Grnt_=0, others 1, owner=0, preempt=0; unchanged for 10 idle cycles.
- owner=0, m0Req_ high, m2Req_ and m3Req_ low at the same edge → next cycle owner=2, m2Grnt_=0; drop m2Req_ → next cycle owner=3.
- owner=3, only m1Req_ low, m3Req_ high → owner wraps to 1 after one cycle, with no skip to 0.
- MAX_HOLD=16: m1 owns with m1Req_ low; m2Req_ goes low at cycle T → preempt=1 and owner=2 at cycle T+16, preempt back to 0 at T+17.
- owner=1, m1Req_ goes high in the same cycle hold reaches 15 with m2Req_ low → owner=2, preempt stays 0.
- reset_ low for one edge while owner=3 with all requests low → next cycle owner=0, m0Grnt_=0, hold=0.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: request/grant bundle shared by the four bus masters and the
// round-robin arbiter.
//
// Handshake: a master asserts its mNReq_ low for as long as it wants the bus.
// It owns the bus in every cycle in which its mNGrnt_ is low. Exactly one
// grant is low in every cycle. A master gives up the bus by raising mNReq_.
// The grant moves on the clock edge after that, and only if someone else is
// asking. There is no separate acknowledge: a low grant means ownership.
//
// Signals:
//   m0Req_..m3Req_    master -> arbiter  active-low requests
//   m0Grnt_..m3Grnt_  arbiter -> master  active-low registered grants
//   owner             arbiter -> master  index of the current owner
//   preempt           arbiter -> master  one-cycle pulse after a forced handover
//   hold              arbiter -> master  tenure counter (debug/observation)
interface bus_arbiter_if #(
  parameter int HOLD_W = 8
);
  logic              m0Req_;
  logic              m1Req_;
  logic              m2Req_;
  logic              m3Req_;
  logic              m0Grnt_;
  logic              m1Grnt_;
  logic              m2Grnt_;
  logic              m3Grnt_;
  logic [1:0]        owner;
  logic              preempt;
  logic [HOLD_W-1:0] hold;

  modport master (
    output m0Req_, m1Req_, m2Req_, m3Req_,
    input  m0Grnt_, m1Grnt_, m2Grnt_, m3Grnt_, owner, preempt, hold
  );

  modport slave (
    input  m0Req_, m1Req_, m2Req_, m3Req_,
    output m0Grnt_, m1Grnt_, m2Grnt_, m3Grnt_, owner, preempt, hold
  );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: four-master round-robin bus arbiter with a tenure limit.
//
// Ports:
//   clk     system clock, all state updates on the rising edge
//   reset_  synchronous active-low reset
//   bus     bus_arbiter_if.slave: requests in; grants, owner, preempt and
//           the tenure counter out. All outputs come straight from flops, so
//           there is no combinational path from any request to any output.
//
// The bus always has an owner. Ownership moves to the next requester in
// round-robin order (owner+1, +2, +3) when the owner releases, or when the
// owner has held the bus for MAX_HOLD cycles while others were waiting.
// MAX_HOLD = 0 disables the tenure limit.
module bus_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 8
) (
  input  logic          clk,
  input  logic          reset_,
  bus_arbiter_if.slave  bus
);

  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam bit                LIMIT_ON  = (MAX_HOLD != 0);

  // State: owner, tenure counter, grant decode of owner, preempt pulse.
  logic [1:0]        owner_q, owner_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [3:0]        grnt_q, grnt_d;
  logic              preempt_q, preempt_d;

  // Next-state helpers.
  logic [3:0] req;
  logic       own_req;
  logic       any_other;
  logic [1:0] winner;
  logic       release_ev;
  logic       preempt_ev;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      owner_q   <= 2'd0;
      hold_q    <= '0;
      grnt_q    <= 4'b1110;
      preempt_q <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      hold_q    <= hold_d;
      grnt_q    <= grnt_d;
      preempt_q <= preempt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    req       = ~{bus.m3Req_, bus.m2Req_, bus.m1Req_, bus.m0Req_};
    own_req   = req[owner_q];
    any_other = |(req & ~(4'b0001 << owner_q));

    // Walk the search list from farthest to nearest so the nearest
    // requester after the owner ends up as the winner.
    winner = owner_q;
    for (int k = 3; k >= 1; k--) begin
      if (req[owner_q + 2'(k)]) winner = owner_q + 2'(k);
    end

    // A release takes priority over the tenure limit, so a release on the
    // same edge as the limit is never reported as a preemption.
    release_ev = !own_req && any_other;
    preempt_ev = LIMIT_ON && own_req && any_other && (hold_q == HOLD_LAST);

    owner_d   = (release_ev || preempt_ev) ? winner : owner_q;
    preempt_d = preempt_ev;
    grnt_d    = ~(4'b0001 << owner_d);

    // The counter only runs while the owner holds the bus against
    // competition; any ownership change or lull in contention clears it.
    if (!LIMIT_ON || release_ev || preempt_ev || !own_req || !any_other) begin
      hold_d = '0;
    end else if (hold_q == HOLD_MAX) begin
      hold_d = hold_q;
    end else begin
      hold_d = hold_q + 1'b1;
    end
  end

  // Output logic: everything is driven from registers.
  always_comb begin
    bus.m0Grnt_ = grnt_q[0];
    bus.m1Grnt_ = grnt_q[1];
    bus.m2Grnt_ = grnt_q[2];
    bus.m3Grnt_ = grnt_q[3];
    bus.owner   = owner_q;
    bus.preempt = preempt_q;
    bus.hold    = hold_q;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  localparam int HOLD_W = 8;
  // {owner[1:0], grants[3:0] (m3..m0), preempt, hold[HOLD_W-1:0]}
  localparam int W = 2 + 4 + 1 + HOLD_W;

  logic clk;
  logic reset_;

  bus_arbiter_if #(.HOLD_W(HOLD_W)) bus ();

  bus_arbiter #(.MAX_HOLD(16), .HOLD_W(HOLD_W)) dut (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    reset_     = 1'b0;
    bus.m0Req_ = 1'b1;
    bus.m1Req_ = 1'b1;
    bus.m2Req_ = 1'b1;
    bus.m3Req_ = 1'b1;
  end

  // Scoreboard.
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [W-1:0] pack_exp(input logic [1:0] own,
                                             input logic pre,
                                             input int unsigned hold);
    logic [3:0] g;
    g = 4'b1111;
    g[own] = 1'b0;
    return {own, g, pre, HOLD_W'(hold)};
  endfunction

  // Driver: apply one cycle of inputs and the state expected after the edge.
  // req_v is {m3Req_, m2Req_, m1Req_, m0Req_}, active-low.
  task automatic cyc(input logic rst_v, input logic [3:0] req_v,
                     input logic [1:0] own, input logic pre,
                     input int unsigned hold);
    @(negedge clk);
    reset_     = rst_v;
    bus.m0Req_ = req_v[0];
    bus.m1Req_ = req_v[1];
    bus.m2Req_ = req_v[2];
    bus.m3Req_ = req_v[3];
    exp_q.push_back(pack_exp(own, pre, hold));
  endtask

  // Monitor: the DUT presents a new state every cycle; compare it against
  // the oldest expectation.
  always @(posedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] exp_v;
    logic [3:0]   g;
    #1;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      g     = {bus.m3Grnt_, bus.m2Grnt_, bus.m1Grnt_, bus.m0Grnt_};
      act   = {bus.owner, g, bus.preempt, bus.hold};
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL state t=%0t actual owner=%0d grnt=%b pre=%b hold=%0d required owner=%0d grnt=%b pre=%b hold=%0d",
                 $time, act[W-1 -: 2], act[W-3 -: 4], act[HOLD_W], act[HOLD_W-1:0],
                 exp_v[W-1 -: 2], exp_v[W-3 -: 4], exp_v[HOLD_W], exp_v[HOLD_W-1:0]);
      end
      checks++;
      if ($countones(~g) != 1 || g[bus.owner] !== 1'b0) begin
        errors++;
        $display("FAIL grant_onehot t=%0t actual grnt=%b owner=%0d required one low grant at owner",
                 $time, g, bus.owner);
      end
    end
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    int budget;

    // Reset, then idle with no requests: parked on m0.
    cyc(1'b0, 4'hF, 2'd0, 1'b0, 0);
    cyc(1'b0, 4'hF, 2'd0, 1'b0, 0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 4'hF, 2'd0, 1'b0, 0);

    // m2 and m3 request together while m0 idle: m2 is nearer, then m3.
    cyc(1'b1, 4'h3, 2'd2, 1'b0, 0);
    cyc(1'b1, 4'h7, 2'd3, 1'b0, 0);
    // Owner 3 releases, only m1 asks: wrap to 1 without stopping at 0.
    cyc(1'b1, 4'hD, 2'd1, 1'b0, 0);
    // m1 alone: no contention, counter stays 0.
    cyc(1'b1, 4'hD, 2'd1, 1'b0, 0);
    cyc(1'b1, 4'hD, 2'd1, 1'b0, 0);

    // m2 starts waiting: counter climbs, 16th edge forces handover to m2.
    for (int k = 1; k <= 15; k++) cyc(1'b1, 4'h9, 2'd1, 1'b0, k);
    cyc(1'b1, 4'h9, 2'd2, 1'b1, 0);
    // Pulse lasts one cycle; m1 still waiting, so m2's tenure starts counting.
    cyc(1'b1, 4'h9, 2'd2, 1'b0, 1);
    // m2 releases with m1 and m3 waiting: m3 is served before preempted m1.
    cyc(1'b1, 4'h5, 2'd3, 1'b0, 0);
    cyc(1'b1, 4'hD, 2'd1, 1'b0, 0);

    // Release on the same edge the limit would fire: plain release.
    for (int k = 1; k <= 15; k++) cyc(1'b1, 4'h9, 2'd1, 1'b0, k);
    cyc(1'b1, 4'hB, 2'd2, 1'b0, 0);

    // Move to m3 with all requesting, then reset mid-tenure.
    cyc(1'b1, 4'h7, 2'd3, 1'b0, 0);
    cyc(1'b1, 4'h0, 2'd3, 1'b0, 1);
    cyc(1'b1, 4'h0, 2'd3, 1'b0, 2);
    cyc(1'b0, 4'h0, 2'd0, 1'b0, 0);
    // Out of reset with everyone idle: parked on m0.
    cyc(1'b1, 4'hF, 2'd0, 1'b0, 0);
    cyc(1'b1, 4'hF, 2'd0, 1'b0, 0);

    // Drain the scoreboard with a bounded wait.
    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual pending=%0d required pending=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
